// File: rtl/idma_tilelink_pkg.sv
// Shared TileLink-UH types, opcodes and sizing helpers for the iDMA TileLink tasks.
package idma_tilelink_pkg;

  localparam int unsigned TlStrbWidth   = 16;
  localparam int unsigned TlAddrWidth   = 32;
  localparam int unsigned TlSizeWidth   = 4;
  localparam int unsigned TlSourceWidth = 4;
  localparam int unsigned TlOffWidth    = $clog2(TlStrbWidth);

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] AccessAck      = 3'd0;

  function automatic int unsigned beat_cnt_width(input int unsigned burst_length,
                                                 input int unsigned strb_width);
    return $clog2(burst_length / strb_width) + 1;
  endfunction

  typedef logic [7:0]             byte_t;
  typedef logic [TlStrbWidth-1:0] strb_t;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [2:0]               param;
    logic [TlSizeWidth-1:0]   size;
    logic [TlSourceWidth-1:0] source;
    logic [TlAddrWidth-1:0]   address;
    strb_t                    mask;
    byte_t [TlStrbWidth-1:0]  data;
    logic                     corrupt;
  } tl_a_chan_t;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [1:0]               param;
    logic [TlSizeWidth-1:0]   size;
    logic [TlSourceWidth-1:0] source;
    logic                     sink;
    logic                     denied;
    byte_t [TlStrbWidth-1:0]  data;
    logic                     corrupt;
  } tl_d_chan_t;

  typedef struct packed {
    tl_a_chan_t a;
    logic       a_valid;
    logic       d_ready;
  } write_req_t;

  typedef struct packed {
    logic       a_ready;
    tl_d_chan_t d;
    logic       d_valid;
  } write_rsp_t;

  typedef struct packed {
    logic [TlOffWidth-1:0] offset;
    logic [TlOffWidth-1:0] tailer;
    logic [TlOffWidth-1:0] shift;
    logic                  is_single;
  } w_dp_req_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       user;
  } w_dp_rsp_t;

  typedef struct packed {
    tl_a_chan_t a_chan;
  } tl_meta_t;

  typedef struct packed {
    tl_meta_t tilelink;
  } write_meta_chan_t;

endpackage

// File: rtl/idma_tilelink_write_beat_ctr.sv
// Tracks the position inside an A-channel burst: first-beat flag, beats remaining, last flag.
// Combinational last, state updates one cycle after each beat handshake; no backpressure of its own.
module idma_tilelink_write_beat_ctr
  import idma_tilelink_pkg::*;
#(
  parameter int unsigned StrbWidth   = 16,
  parameter int unsigned BurstLength = 64,
  parameter int unsigned SizeWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SizeWidth-1:0] size,
  input  logic                 is_single,
  input  logic                 beat_hs,
  output logic                 first,
  output logic                 last
);

  localparam int unsigned CntWidth = beat_cnt_width(BurstLength, StrbWidth);
  localparam int unsigned MaxBeats = BurstLength / StrbWidth;

  logic [31:0]         beats_raw;
  logic [CntWidth-1:0] beats_total;
  logic [CntWidth-1:0] beats_left_q;
  logic                first_q;

  // Sub-beat transfers still occupy one beat; oversize requests clamp to a full burst.
  always_comb begin
    beats_raw = (32'd1 << size) >> $clog2(StrbWidth);
    if (beats_raw == 32'd0) beats_raw = 32'd1;
    if (beats_raw > MaxBeats) beats_raw = 32'(MaxBeats);
  end

  assign beats_total = CntWidth'(beats_raw);
  assign first       = first_q;
  assign last        = is_single
                     | (!first_q && beats_left_q == CntWidth'(1))
                     | ( first_q && beats_total  == CntWidth'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_q      <= 1'b1;
      beats_left_q <= '0;
    end else if (beat_hs) begin
      first_q <= last;
      if (first_q) beats_left_q <= beats_total - CntWidth'(1);
      else         beats_left_q <= beats_left_q - CntWidth'(1);
    end
  end

endmodule

// File: rtl/idma_tilelink_write.sv
// iDMA TileLink-UH write task: zero-latency buffer-to-A-channel beats, AccessAcks passed to w_dp in order.
// A beats stall on buffer bytes, descriptor, header or a full outstanding window; D stalls on w_dp_ready_i. Optional IDMA_TILELINK_WRITE_ERR_STICKY_EN.
module idma_tilelink_write
  import idma_tilelink_pkg::*;
#(
  parameter int unsigned StrbWidth      = 16,
  parameter int unsigned BurstLength    = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter type byte_t            = idma_tilelink_pkg::byte_t,
  parameter type strb_t            = idma_tilelink_pkg::strb_t,
  parameter type write_req_t       = idma_tilelink_pkg::write_req_t,
  parameter type write_rsp_t       = idma_tilelink_pkg::write_rsp_t,
  parameter type w_dp_req_t        = idma_tilelink_pkg::w_dp_req_t,
  parameter type w_dp_rsp_t        = idma_tilelink_pkg::w_dp_rsp_t,
  parameter type write_meta_chan_t = idma_tilelink_pkg::write_meta_chan_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  w_dp_req_t               w_dp_req_i,
  input  logic                    w_dp_valid_i,
  output logic                    w_dp_ready_o,
  output w_dp_rsp_t               w_dp_rsp_o,
  output logic                    w_dp_valid_o,
  input  logic                    w_dp_ready_i,
  input  write_meta_chan_t        write_meta_req_i,
  input  logic                    write_meta_valid_i,
  output logic                    write_meta_ready_o,
  output write_req_t              write_req_o,
  input  write_rsp_t              write_rsp_i,
`ifdef IDMA_TILELINK_WRITE_ERR_STICKY_EN
  output logic                    err_sticky_o,
  input  logic                    err_clear_i,
`endif
  input  byte_t [StrbWidth-1:0]   buffer_out_i,
  input  strb_t                   buffer_out_valid_i,
  output strb_t                   buffer_out_ready_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  logic            first, last;
  logic            data_ok, a_valid, beat_hs, last_hs;
  logic            d_ready, d_hs;
  logic            outst_full;
  logic [OutW-1:0] outst_q;
  strb_t           mask, mask_out;
  logic            unused_in;

  idma_tilelink_write_beat_ctr #(
    .StrbWidth   (StrbWidth),
    .BurstLength (BurstLength),
    .SizeWidth   ($bits(write_meta_req_i.tilelink.a_chan.size))
  ) i_beat_ctr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .size      (write_meta_req_i.tilelink.a_chan.size),
    .is_single (w_dp_req_i.is_single),
    .beat_hs   (beat_hs),
    .first     (first),
    .last      (last)
  );

  always_comb begin
    mask = '1;
    if (first) mask &= {StrbWidth{1'b1}} << w_dp_req_i.offset;
    if (last && w_dp_req_i.tailer != '0)
      mask &= {StrbWidth{1'b1}} >> (StrbWidth - 32'(w_dp_req_i.tailer));
    // Buffer bytes sit rotated by the realignment shift relative to bus lanes.
    mask_out = strb_t'({mask, mask} >> w_dp_req_i.shift);
  end

  assign data_ok    = &(buffer_out_valid_i | ~mask_out);
  assign outst_full = (outst_q == OutW'(MaxOutstanding));
  assign a_valid    = !rst_i & w_dp_valid_i & write_meta_valid_i & data_ok & ~(first & outst_full);
  assign beat_hs    = a_valid & write_rsp_i.a_ready;
  assign last_hs    = beat_hs & last;
  assign d_ready    = !rst_i & w_dp_ready_i;
  assign d_hs       = write_rsp_i.d_valid & d_ready;

  assign buffer_out_ready_o = beat_hs ? mask_out : '0;
  assign w_dp_ready_o       = last_hs;
  assign write_meta_ready_o = last_hs;
  assign w_dp_valid_o       = !rst_i & write_rsp_i.d_valid;

  always_comb begin
    write_req_o           = '0;
    write_req_o.a         = write_meta_req_i.tilelink.a_chan;
    write_req_o.a.mask    = mask;
    write_req_o.a.data    = buffer_out_i;
    write_req_o.a.corrupt = 1'b0;
    write_req_o.a_valid   = a_valid;
    write_req_o.d_ready   = d_ready;
  end

  always_comb begin
    w_dp_rsp_o      = '0;
    w_dp_rsp_o.resp = {write_rsp_i.d.corrupt, write_rsp_i.d.denied};
  end

  // Stray acks with nothing outstanding pass through without wrapping the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q <= '0;
    end else begin
      case ({last_hs, d_hs})
        2'b10:   outst_q <= outst_q + OutW'(1);
        2'b01:   if (outst_q != '0) outst_q <= outst_q - OutW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

`ifdef IDMA_TILELINK_WRITE_ERR_STICKY_EN
  logic err_sticky_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                                        err_sticky_q <= 1'b0;
    else if (d_hs && (write_rsp_i.d.corrupt || write_rsp_i.d.denied)) err_sticky_q <= 1'b1;
    else if (err_clear_i)                                             err_sticky_q <= 1'b0;
  end

  assign err_sticky_o = err_sticky_q;
`endif

  assign unused_in = ^{write_rsp_i, write_meta_req_i};

endmodule

// File: doc/idma_tilelink_write.md
Name: idma_tilelink_write

Overview:
Write task of the iDMA transport layer for a TileLink-UH manager port; the counterpart of the TileLink read task.
- Pops realigned bytes from the shared byte buffer and merges them with the A-channel header from the write meta channel.
- Issues PutFullData/PutPartialData bursts and collects one AccessAck per burst.
- Reports each ack to the write datapath as a w_dp response, in order.

Parameters:
StrbWidth, 16, bus width in bytes (power of two)
BurstLength, 64, max burst in bytes (multiple of StrbWidth)
MaxOutstanding, 4, max bursts issued but not yet acked
byte_t / strb_t, logic, byte and per-byte-strobe types
write_req_t / write_rsp_t, logic, TileLink manager request/response structs
w_dp_req_t / w_dp_rsp_t, logic, write datapath request (offset, tailer, shift, is_single) / response (resp, user)
write_meta_chan_t, logic, meta struct carrying tilelink.a_chan header

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
w_dp_req_i  in  w_dp_req_t  current burst descriptor
w_dp_valid_i  in  1  descriptor valid
w_dp_ready_o  out  1  descriptor consumed (last beat handshake)
w_dp_rsp_o  out  w_dp_rsp_t  burst response
w_dp_valid_o  out  1  response valid
w_dp_ready_i  in  1  response accepted
write_meta_req_i  in  write_meta_chan_t  A header (opcode, size, source, address)
write_meta_valid_i  in  1  header valid
write_meta_ready_o  out  1  header consumed
write_req_o  out  write_req_t  a, a_valid, d_ready
write_rsp_i  in  write_rsp_t  a_ready, d, d_valid
buffer_out_i  in  byte_t[StrbWidth]  buffer head bytes
buffer_out_valid_i  in  strb_t  per-byte valid
buffer_out_ready_o  out  strb_t  per-byte pop

Behaviour:
- Reset:
  - counters 0; first_q=1.
  - Outputs all 0 except write_req_o.a, which mirrors the meta header (a_valid=0).
- Write-aligned mask:
  - Start from all ones.
  - First beat: AND with '1<<offset.
  - Last beat with tailer!=0: AND with '1>>(StrbWidth-tailer).
  - is_single: first and last apply together.
- Buffer-side mask: mask_out = ({mask,mask} >> shift) truncated to StrbWidth.
- Beat readiness: data_ok = &(buffer_out_valid_i | ~mask_out).
- A channel:
  - a_valid = w_dp_valid_i & write_meta_valid_i & data_ok & ~(first_q & outst_full).
  - a.data = buffer_out_i; a.mask = mask; all other a fields = header, held constant for the whole burst.
- Pop: buffer_out_ready_o = (a_valid & a_ready) ? mask_out : 0. Purely combinational, zero latency.
- Beat counter:
  - On the first beat handshake, load beats_left = max(1, (1<<size)>>log2(StrbWidth)) - 1.
  - Decrement on each later beat.
  - last = is_single | (!first_q & beats_left==1) | (first_q & computed beats==1).
  - first_q clears on a non-last handshake and sets on a last handshake.
- On the last beat handshake: w_dp_ready_o=1 and write_meta_ready_o=1 in the same cycle.
- Outstanding counter:
  - +1 on last-beat A handshake; -1 on D handshake; both in the same cycle leaves it unchanged.
  - outst_full = (count==MaxOutstanding).
  - Blocks only the first beat of a new burst; a burst in flight always completes.
- D channel:
  - d_ready = w_dp_ready_i; w_dp_valid_o = d_valid.
  - resp = {d.corrupt, d.denied}.
  - A D beat arriving with count==0 is accepted and passed through; the counter saturates at 0.
- Errors never abort the A burst; the error is reported only via resp.
- Reset mid-burst: all state clears on the next edge; the next descriptor is treated as a first beat.

Optional Feature:
IDMA_TILELINK_WRITE_ERR_STICKY_EN
- Defined: adds ports err_sticky_o (out, 1) and err_clear_i (in, 1).
  - err_sticky_o sets on the cycle after a D handshake with corrupt|denied.
  - It clears on err_clear_i; set wins when both occur in the same cycle.
  - Reset value 0.
- Undefined: the ports and register are absent; behaviour is otherwise identical.

Decomposition:
- Package idma_tilelink_pkg: opcode constants PutFullData=3'd0, PutPartialData=3'd1, AccessAck=3'd0, and the beat-count width function clog2(BurstLength/StrbWidth)+1.
- One sub-module, idma_tilelink_write_beat_ctr: beats_left, first_q, last generation.
- Outstanding counter and masks stay in the top.

Test Plan:
1. size=4, offset=0, tailer=0, shift=0, is_single=1, all buffer bytes valid -> one beat: a.mask=16'hFFFF, buffer_out_ready_o=16'hFFFF, w_dp_ready_o and meta_ready pulse together; D ack -> w_dp_valid_o with resp=2'b00.
2. size=6, offset=3, tailer=5 -> four beats with a.mask 16'hFFF8, 16'hFFFF, 16'hFFFF, 16'h001F; meta_ready_o high only on beat 4.
3. offset=0, shift=4, with buffer_out_valid_i=16'hFFEF -> a_valid stays 0 and nothing pops; set bit 4 -> beat issues, ready=16'hFFFF.
4. MaxOutstanding=2, three single-beat bursts with D held off -> third a_valid stays 0; one D ack -> third issues the next cycle.
5. D with denied=1 and corrupt=0 -> resp=2'b01; with the macro defined, err_sticky_o=1 until err_clear_i.
6. rst_i asserted after 2 of 4 beats -> w_dp_valid_o=0, counter 0; the next size=5 descriptor issues 2 beats, starting with the first-beat mask.
